psum_requant_drain: RTL and testbench
=====================================

Name: psum_requant_drain

Overview:
- Downstream consumer of computing_core's o_result bus: 896 lanes × 10-bit partial sums, 8960 bits total.
- Accumulates partial sums across input-channel tiles in per-lane signed accumulators.
- On the last tile, applies ReLU, right-shift with rounding, and saturation to 4-bit activations.
- Drains the result as 28 beats of 32 lanes over a valid/ready stream, which feeds activation write-back.

Parameters:
- N_OUT, 896, number of result lanes.
- PSUM_W, 10, signed partial-sum width per lane.
- ACC_W, 16, signed accumulator width per lane.
- OUT_W, 4, unsigned output activation width.
- OUT_LANES, 32, lanes per output beat; N_OUT must be a multiple of it.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_psum  in  N_OUT*PSUM_W  partial sums; lane k is at [k*PSUM_W +: PSUM_W].
- i_psum_valid  in  1  partial-sum tile valid.
- i_first  in  1  first tile of a group; qualifies i_psum_valid.
- i_last  in  1  last tile of a group; qualifies i_psum_valid.
- i_shift  in  4  requant right-shift, sampled on the accepted last tile.
- o_psum_ready  out  1  block can accept a tile.
- o_data  out  OUT_LANES*OUT_W  output beat; lane j is at [j*OUT_W +: OUT_W].
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat.
- o_beat_idx  out  5  current beat index, 0..27.
- o_sat_flag  out  1  sticky accumulator saturation flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM; all accumulators 0; shift register 0; beat counter 0.
  - o_valid=0, o_psum_ready=1, o_sat_flag=0.
  - Reset mid-drain abandons the group. No partial beats are issued afterwards.
- ACCUM state:
  - o_psum_ready=1.
  - A tile is accepted when i_psum_valid && o_psum_ready.
  - On accept with i_first=1: acc[k] = sext(i_psum[k]).
  - On accept with i_first=0: acc[k] = sat(acc[k] + sext(i_psum[k])).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On accept with i_last=1: latch i_shift, go to DRAIN next cycle.
  - i_first and i_last together: a single-tile group. The acc is loaded, then DRAIN.
  - i_psum_valid=0: the accumulators hold.
- DRAIN state:
  - o_psum_ready=0. Tiles are not accepted and upstream must hold them.
  - o_valid=1 on the first DRAIN cycle, i.e. 1 cycle after the last-tile accept.
  - Lane j of beat b uses q(acc[b*32+j]).
  - r = max(acc, 0).
  - shift=0: q = r. shift>0: q = (r + 2^(shift-1)) >> shift.
  - q is then clamped to 2^OUT_W-1 (15).
  - o_data and o_beat_idx are driven from registers and the beat counter only. There is no combinational path from i_ready to o_data.
  - o_data holds stable while o_valid && !i_ready.
  - On the handshake o_valid && i_ready the beat counter increments.
  - On the handshake at beat 27:
    - Clear all accumulators and the beat counter; o_valid=0 next cycle.
    - Return to ACCUM; o_psum_ready=1 next cycle.
    - A tile is never accepted in the same cycle as the final beat.
- Accumulators are frozen throughout DRAIN.
- Throughput: a group of T tiles takes T accept cycles plus ≥28 drain cycles.

Optional Feature:
- PSUM_SAT_STAT_EN defined:
  - o_sat_flag is set sticky when any lane's add clamps during ACCUM.
  - It clears on rst_n=0 and on a tile accepted with i_first=1.
  - The first tile itself cannot saturate, because PSUM_W < ACC_W.
- Not defined: o_sat_flag is tied to 0. No saturation-detect logic is synthesised. The port is still present.

Decomposition:
- Package psum_acc_pkg:
  - Constants N_OUT, PSUM_W, ACC_W, OUT_W, OUT_LANES.
  - N_BEATS = N_OUT/OUT_LANES = 28.
  - BEAT_IDX_W = 5.
  - State enum {ACCUM, DRAIN}.
- Sub-module psum_requant_lane (combinational):
  - ACC_W in, shift in, OUT_W out.
  - Implements ReLU, rounding, shift and clamp.
  - Instantiated OUT_LANES times on the accumulators muxed by the beat counter.

Test Plan:
- Reset check:
  - Hold rst_n=0 for 2 cycles.
  - Required: o_valid=0, o_psum_ready=1, o_sat_flag=0, o_beat_idx=0.
- Single-tile group:
  - Stimulus: all lanes psum=37, i_first=i_last=1, i_shift=3.
  - Required: o_valid rises 1 cycle later; all 28 beats have every lane = 5.
  - Required: o_psum_ready=1 one cycle after beat 27.
- Three-tile group with ReLU and clamp:
  - Stimulus: lane 0 gets tiles -20,+5,-10; lane 1 gets tiles 100,100,100; shift=2.
  - Required: lane 0 acc=-25, output 0; lane 1 acc=300, output 15.
  - Required: lane 2, all zeros, outputs 0.
- Backpressure:
  - Stimulus: hold i_ready=0 for 5 cycles during beat 3, with tile valid asserted throughout drain.
  - Required: o_data and o_beat_idx=3 stable; o_psum_ready=0; exactly 28 handshakes total; no tile accepted during drain.
- Saturation (with PSUM_SAT_STAT_EN):
  - Stimulus: 65 tiles of psum=511, shift=0.
  - Required: acc=32767; output 15; o_sat_flag=1.
  - Required: the next group's i_first tile clears o_sat_flag.
- Reset mid-drain:
  - Stimulus: assert rst_n=0 at beat 10.
  - Required: o_valid=0 next cycle. A following single-tile group of psum=3, shift=0 gives all lanes 3, with no residue from the abandoned group.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared constants, state type and saturating-add helpers for psum_requant_drain.
package psum_acc_pkg;
  localparam int N_OUT      = 896;
  localparam int PSUM_W     = 10;
  localparam int ACC_W      = 16;
  localparam int OUT_W      = 4;
  localparam int OUT_LANES  = 32;
  localparam int N_BEATS    = N_OUT / OUT_LANES;
  localparam int BEAT_IDX_W = 5;
  localparam int LANE_IDX_W = $clog2(N_OUT);

  typedef enum logic {ACCUM, DRAIN} state_e;

  function automatic logic signed [ACC_W:0] wide_add(input logic signed [ACC_W-1:0] a,
                                                      input logic [PSUM_W-1:0] p);
    return {a[ACC_W-1], a} + {{(ACC_W+1-PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

  // A one-bit-wider sum overflowed when its top two bits disagree.
  function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [ACC_W:0] s);
    return (s[ACC_W] ^ s[ACC_W-1]) ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/psum_requant_lane.sv
// psum_requant_lane: ReLU, round-half-up right shift and clamp of one accumulator to OUT_W bits.
module psum_requant_lane
  import psum_acc_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [3:0]              shift_i,
  output logic [OUT_W-1:0]        q_o
);
  logic [ACC_W:0] r, rnd, q;
  always_comb begin
    r = acc_i[ACC_W-1] ? '0 : {1'b0, acc_i};
    rnd = (shift_i == 4'd0) ? '0 : (ACC_W+1)'(1) << (shift_i - 4'd1);
    q = (r + rnd) >> shift_i;
    q_o = (q > (ACC_W+1)'(2**OUT_W - 1)) ? '1 : q[OUT_W-1:0];
  end
endmodule

// File: rtl/psum_requant_drain.sv
// psum_requant_drain: accumulate partial-sum tiles per lane, then drain requantised 4-bit beats.
// Optional PSUM_SAT_STAT_EN enables the sticky accumulator saturation flag.
module psum_requant_drain
  import psum_acc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_OUT*PSUM_W-1:0]     i_psum,
  input  logic                        i_psum_valid,
  input  logic                        i_first,
  input  logic                        i_last,
  input  logic [3:0]                  i_shift,
  output logic                        o_psum_ready,
  output logic [OUT_LANES*OUT_W-1:0]  o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [BEAT_IDX_W-1:0]       o_beat_idx,
  output logic                        o_sat_flag
);
  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [N_OUT];
  logic signed [ACC_W-1:0] acc_d [N_OUT];
  logic signed [ACC_W-1:0] sel [OUT_LANES];
  logic [3:0]              shift_q, shift_d;
  logic [BEAT_IDX_W-1:0]   beat_q, beat_d;
  logic                    accept, fire, last_beat;
`ifdef PSUM_SAT_STAT_EN
  logic signed [ACC_W:0]   s;
  logic                    sat_any, sat_q, sat_d;
`endif

  assign o_psum_ready = state_q == ACCUM;
  assign o_valid      = state_q == DRAIN;
  assign o_beat_idx   = beat_q;
  assign accept       = i_psum_valid && o_psum_ready;
  assign fire         = o_valid && i_ready;
  assign last_beat    = fire && beat_q == BEAT_IDX_W'(N_BEATS - 1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d = beat_q;
    acc_d = acc_q;
`ifdef PSUM_SAT_STAT_EN
    s = '0;
    sat_any = 1'b0;
`endif
    if (accept) begin
      // A first tile adds onto zero, which loads the sign-extended psum.
      for (int k = 0; k < N_OUT; k++) begin
`ifdef PSUM_SAT_STAT_EN
        s = wide_add(i_first ? '0 : acc_q[k], i_psum[k*PSUM_W +: PSUM_W]);
        acc_d[k] = clamp_acc(s);
        sat_any = sat_any | (s[ACC_W] ^ s[ACC_W-1]);
`else
        acc_d[k] = clamp_acc(wide_add(i_first ? '0 : acc_q[k], i_psum[k*PSUM_W +: PSUM_W]));
`endif
      end
      shift_d = i_last ? i_shift : shift_q;
      state_d = i_last ? DRAIN : ACCUM;
    end
    if (fire) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
      state_d = last_beat ? ACCUM : DRAIN;
      if (last_beat)
        for (int k = 0; k < N_OUT; k++) acc_d[k] = '0;
    end
  end

`ifdef PSUM_SAT_STAT_EN
  assign sat_d = (accept && i_first) ? 1'b0 : sat_q | (accept && sat_any);
  assign o_sat_flag = sat_q;
`else
  assign o_sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      shift_q <= '0;
      beat_q <= '0;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= '0;
`ifdef PSUM_SAT_STAT_EN
      sat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      beat_q <= beat_d;
      for (int k = 0; k < N_OUT; k++) acc_q[k] <= acc_d[k];
`ifdef PSUM_SAT_STAT_EN
      sat_q <= sat_d;
`endif
    end
  end

  always_comb begin
    for (int j = 0; j < OUT_LANES; j++)
      sel[j] = acc_q[LANE_IDX_W'(beat_q) * LANE_IDX_W'(OUT_LANES) + LANE_IDX_W'(j)];
  end

  for (genvar j = 0; j < OUT_LANES; j++) begin : g_lane
    psum_requant_lane u_lane (
      .acc_i   (sel[j]),
      .shift_i (shift_q),
      .q_o     (o_data[j*OUT_W +: OUT_W])
    );
  end
endmodule

// File: tb/tb_psum_requant_drain.sv
// tb_psum_requant_drain: directed tests against an integer model of the accumulate/requant/drain flow.
module tb_psum_requant_drain;
  import psum_acc_pkg::*;

`ifdef PSUM_SAT_STAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [N_OUT*PSUM_W-1:0]    i_psum = '0;
  logic                       i_psum_valid = 1'b0, i_first = 1'b0, i_last = 1'b0, i_ready = 1'b0;
  logic [3:0]                 i_shift = '0;
  logic                       o_psum_ready, o_valid, o_sat_flag;
  logic [OUT_LANES*OUT_W-1:0] o_data;
  logic [BEAT_IDX_W-1:0]      o_beat_idx;

  int errors = 0, checks = 0, hs = 0;
  bit started = 1'b0;

  int   m_acc [N_OUT];
  bit   m_drain = 1'b0, m_sat = 1'b0;
  int   m_shift = 0, m_beat = 0, mp, mv;
  logic [OUT_LANES*OUT_W-1:0] exp_data;

  always #5 clk = ~clk;

  psum_requant_drain dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_psum       (i_psum),
    .i_psum_valid (i_psum_valid),
    .i_first      (i_first),
    .i_last       (i_last),
    .i_shift      (i_shift),
    .o_psum_ready (o_psum_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_beat_idx   (o_beat_idx),
    .o_sat_flag   (o_sat_flag)
  );

  function automatic int mq(int a, int sh);
    int r = a < 0 ? 0 : a;
    if (sh > 0) r = (r + (1 << (sh - 1))) / (1 << sh);
    return r > 15 ? 15 : r;
  endfunction

  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // Model: integer accumulators, updated from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) m_acc[k] = 0;
      m_drain = 0; m_sat = 0; m_shift = 0; m_beat = 0;
    end else if (!m_drain) begin
      if (i_psum_valid) begin
        if (i_first) m_sat = 0;
        for (int k = 0; k < N_OUT; k++) begin
          mp = $signed(i_psum[k*PSUM_W +: PSUM_W]);
          mv = (i_first ? 0 : m_acc[k]) + mp;
          if (mv > 32767) begin mv = 32767; m_sat = 1; end
          else if (mv < -32768) begin mv = -32768; m_sat = 1; end
          m_acc[k] = mv;
        end
        if (i_last) begin m_shift = i_shift; m_drain = 1; end
      end
    end else if (i_ready) begin
      if (m_beat == N_BEATS - 1) begin
        for (int k = 0; k < N_OUT; k++) m_acc[k] = 0;
        m_beat = 0; m_drain = 0;
      end else m_beat++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      exp_data = '0;
      for (int j = 0; j < OUT_LANES; j++)
        exp_data[j*OUT_W +: OUT_W] = 4'(mq(m_acc[m_beat*OUT_LANES + j], m_shift));
      chk("valid", o_valid, m_drain);
      chk("psum_ready", o_psum_ready, !m_drain);
      chk("beat_idx", o_beat_idx, m_beat);
      chk("sat_flag", o_sat_flag, SAT_EN & m_sat);
      if (m_drain) chk("data", o_data, exp_data);
    end
  end

  task automatic lane(int k, int v);
    i_psum[k*PSUM_W +: PSUM_W] = PSUM_W'(v);
  endtask

  task automatic set_all(int v);
    for (int k = 0; k < N_OUT; k++) lane(k, v);
  endtask

  task automatic send(bit f, bit l, logic [3:0] sh);
    bit rdy = 0;
    int g = 0;
    i_first = f; i_last = l; i_shift = sh; i_psum_valid = 1;
    while (!rdy && g < 100) begin
      rdy = o_psum_ready;
      g++;
      @(posedge clk);
      #1;
    end
    if (!rdy) chk("send_timeout", rdy, 1);
    i_psum_valid = 0;
  endtask

  task automatic drain(int stall_beat, int stall_n, int abort_beat);
    int g = 0, stalled = 0;
    bit done = 0;
    logic [127:0] held = '0;
    while (!done && g < 200) begin
      @(negedge clk);
      g++;
      if (o_valid && int'(o_beat_idx) == abort_beat) begin
        rst_n = 0;
        @(negedge clk);
        chk("abort_valid", o_valid, 0);
        chk("abort_beat", o_beat_idx, 0);
        rst_n = 1;
        done = 1;
      end else if (o_valid && int'(o_beat_idx) == stall_beat && stalled < stall_n) begin
        if (stalled == 0) held = o_data;
        else begin
          chk("bp_data", o_data, held);
          chk("bp_beat", o_beat_idx, 3);
          chk("bp_ready", o_psum_ready, 0);
        end
        i_ready = 0;
        stalled++;
      end else begin
        i_ready = 1;
        if (o_valid) begin
          hs++;
          if (int'(o_beat_idx) == N_BEATS - 1) done = 1;
        end
      end
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    for (int k = 0; k < N_OUT; k++) m_acc[k] = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    started = 1;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_psum_ready, 1);
    chk("rst_sat", o_sat_flag, 0);
    chk("rst_beat", o_beat_idx, 0);
    rst_n = 1;

    set_all(37);
    send(1, 1, 3);
    @(negedge clk);
    chk("single_valid", o_valid, 1);
    chk("single_data", o_data, {32{4'h5}});
    hs = 0;
    drain(-1, 0, -1);
    chk("single_hs", hs, 28);
    @(posedge clk); #1 i_ready = 0;
    @(negedge clk);
    chk("ready_after_last", o_psum_ready, 1);

    set_all(0);
    lane(0, -20); lane(1, 100); send(1, 0, 2);
    lane(0, 5);                 send(0, 0, 2);
    lane(0, -10);               send(0, 1, 2);
    for (int k = 0; k < N_OUT; k++) lane(k, (k % 50) - 10);
    i_first = 1; i_last = 1; i_shift = 1; i_psum_valid = 1;
    @(negedge clk);
    chk("relu_lane0", o_data[3:0], 0);
    chk("clamp_lane1", o_data[7:4], 15);
    chk("zero_lane2", o_data[11:8], 0);
    hs = 0;
    drain(3, 5, -1);
    chk("bp_hs", hs, 28);
    @(posedge clk); #1 i_ready = 0;
    @(negedge clk);
    chk("ready_held", o_psum_ready, 1);
    @(posedge clk); #1 i_psum_valid = 0;
    @(negedge clk);
    chk("held_valid", o_valid, 1);
    hs = 0;
    drain(-1, 0, -1);
    chk("held_hs", hs, 28);
    @(posedge clk); #1 i_ready = 0;

    set_all(511);
    send(1, 0, 0);
    repeat (63) send(0, 0, 0);
    send(0, 1, 0);
    @(negedge clk);
    chk("sat_lane0", o_data[3:0], 15);
    chk("model_sat_acc", m_acc[0], 32767);
    chk("sat_flag_set", o_sat_flag, SAT_EN);
    drain(-1, 0, -1);
    @(posedge clk); #1 i_ready = 0;

    set_all(2);
    send(1, 0, 0);
    @(negedge clk);
    chk("sat_clear", o_sat_flag, 0);
    send(0, 1, 5);
    drain(-1, 0, 10);
    i_ready = 0;

    set_all(3);
    send(1, 1, 0);
    @(negedge clk);
    chk("post_abort_valid", o_valid, 1);
    chk("post_abort_data", o_data, {32{4'h3}});
    drain(-1, 0, -1);
    @(posedge clk); #1 i_ready = 0;
    @(negedge clk);
    chk("final_ready", o_psum_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
